stim_gen: RTL

- Parametrised, multi-waveform digital stimulus generator; the next generation of the counter-plus-sine-ROM source that drives filter benches and DSP datapaths.
- A phase accumulator, advanced by a programmable sample-rate divider, addresses a quarter-wave sine LUT or mode logic.
- Produces signed samples with a valid strobe, so filters can run at a decimated sample rate with selectable waveform, frequency and amplitude.

---
 rtl/stim_gen.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/stim_gen.sv
// Multi-waveform stimulus generator: divider-paced phase accumulator feeding a quarter-wave
// sine LUT plus square/saw/impulse logic, with a two-stage output pipeline and valid strobe.
module stim_gen #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PHASE_WIDTH    = 24,
  parameter int unsigned LUT_ADDR_WIDTH = 10,
  parameter int unsigned DIV_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         load,
  input  logic [1:0]                   mode,
  input  logic [PHASE_WIDTH-1:0]       phase_inc,
  input  logic [DIV_WIDTH-1:0]         rate_div,
  input  logic [3:0]                   amp_shift,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_valid,
  output logic                         phase_wrap
);

  // Top phase bits needed by every waveform; the rest never reach the pipeline.
  localparam int unsigned SnapWidth = (DATA_WIDTH > LUT_ADDR_WIDTH + 2) ?
                                      DATA_WIDTH : LUT_ADDR_WIDTH + 2;
  localparam int unsigned LutDepth  = 1 << LUT_ADDR_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] FullPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] FullNeg = -FullPos;

  typedef enum logic [1:0] {ModeSine, ModeSquare, ModeSaw, ModeImpulse} mode_e;

  // Elaboration-time sine via Taylor series; centred sampling keeps entries non-zero.
  function automatic logic signed [DATA_WIDTH-1:0] sine_entry(input int unsigned i);
    real x;
    real term;
    real sum;
    real amp;
    x    = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(LutDepth);
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = (2.0 ** (DATA_WIDTH - 1)) - 1.0;
    return DATA_WIDTH'($rtoi(sum * amp + 0.5));
  endfunction

  logic signed [DATA_WIDTH-1:0] lut [LutDepth];

  for (genvar i = 0; i < LutDepth; i++) begin : g_lut
    localparam logic signed [DATA_WIDTH-1:0] Entry = sine_entry(i);
    assign lut[i] = Entry;
  end

  // Configuration shadow registers
  mode_e                  mode_q, mode_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [3:0]             shift_q, shift_d;

  // Divider and accumulator
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   wrap_pend_q, wrap_pend_d;
  logic                   tick;
  logic                   carry;
  logic [PHASE_WIDTH-1:0] phase_sum;

  // Snapshot of the tick's phase/config, then mux result, then shifted output
  logic                 v0_q, v0_d;
  logic [SnapWidth-1:0] snap_q, snap_d;
  logic                 w0_q, w0_d;
  mode_e                mode0_q, mode0_d;
  logic [3:0]           shift0_q, shift0_d;

  logic                         v1_q, v1_d;
  logic signed [DATA_WIDTH-1:0] val1_q, val1_d;
  logic                         w1_q, w1_d;
  logic [3:0]                   shift1_q, shift1_d;

  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic                         valid_q, valid_d;
  logic                         pwrap_q, pwrap_d;

  logic [1:0]                   quad;
  logic [LUT_ADDR_WIDTH-1:0]    idx;
  logic [LUT_ADDR_WIDTH-1:0]    lut_addr;
  logic signed [DATA_WIDTH-1:0] mag;
  logic signed [DATA_WIDTH-1:0] mux_val;

  always_comb begin
    mode_d  = mode_q;
    inc_d   = inc_q;
    div_d   = div_q;
    shift_d = shift_q;
    if (load) begin
      mode_d  = mode_e'(mode);
      inc_d   = phase_inc;
      div_d   = rate_div;
      shift_d = amp_shift;
    end

    tick  = enable && (cnt_q == div_q);
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    {carry, phase_sum} = {1'b0, phase_q} + {1'b0, inc_q};
    phase_d     = tick ? phase_sum : phase_q;
    wrap_pend_d = tick ? carry : wrap_pend_q;

    v0_d     = tick;
    snap_d   = snap_q;
    w0_d     = w0_q;
    mode0_d  = mode0_q;
    shift0_d = shift0_q;
    if (tick) begin
      snap_d   = phase_q[PHASE_WIDTH-1 -: SnapWidth];
      w0_d     = wrap_pend_q;
      mode0_d  = mode_q;
      shift0_d = shift_q;
    end
  end

  always_comb begin
    quad     = snap_q[SnapWidth-1 -: 2];
    idx      = snap_q[SnapWidth-3 -: LUT_ADDR_WIDTH];
    lut_addr = quad[0] ? ~idx : idx;
    mag      = lut[lut_addr];
    mux_val  = '0;
    unique case (mode0_q)
      ModeSine:    mux_val = quad[1] ? -mag : mag;
      ModeSquare:  mux_val = snap_q[SnapWidth-1] ? FullNeg : FullPos;
      ModeSaw:     mux_val = {~snap_q[SnapWidth-1], snap_q[SnapWidth-2 -: DATA_WIDTH-1]};
      ModeImpulse: mux_val = w0_q ? FullPos : '0;
    endcase

    v1_d     = v0_q;
    val1_d   = val1_q;
    w1_d     = w1_q;
    shift1_d = shift1_q;
    if (v0_q) begin
      val1_d   = mux_val;
      w1_d     = w0_q;
      shift1_d = shift0_q;
    end

    valid_d = v1_q;
    pwrap_d = v1_q & w1_q;
    out_d   = v1_q ? (val1_q >>> shift1_q) : out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= ModeSine;
      inc_q       <= '0;
      div_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      wrap_pend_q <= 1'b1;
      v0_q        <= 1'b0;
      snap_q      <= '0;
      w0_q        <= 1'b0;
      mode0_q     <= ModeSine;
      shift0_q    <= '0;
      v1_q        <= 1'b0;
      val1_q      <= '0;
      w1_q        <= 1'b0;
      shift1_q    <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      pwrap_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      inc_q       <= inc_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      wrap_pend_q <= wrap_pend_d;
      v0_q        <= v0_d;
      snap_q      <= snap_d;
      w0_q        <= w0_d;
      mode0_q     <= mode0_d;
      shift0_q    <= shift0_d;
      v1_q        <= v1_d;
      val1_q      <= val1_d;
      w1_q        <= w1_d;
      shift1_q    <= shift1_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      pwrap_q     <= pwrap_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign phase_wrap   = pwrap_q;

endmodule
